// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared constants and types for the memory-access stage
// Purpose: register-id sentinel, access size codes, fault codes and FSM state
//          encodings used by mem_access_stage and mem_lane_align.
// Ports:   none (package).
package mem_access_stage_pkg;

  // Register id that the register file treats as "no write".
  localparam logic [6:0] UREG_ZZR = 7'h7F;

  localparam logic [1:0] MSZ_B = 2'd0;
  localparam logic [1:0] MSZ_W = 2'd1;
  localparam logic [1:0] MSZ_L = 2'd2;

  localparam logic [1:0] MAF_NONE  = 2'd0;
  localparam logic [1:0] MAF_ALIGN = 2'd1;
  localparam logic [1:0] MAF_BUS   = 2'd2;
  localparam logic [1:0] MAF_TMO   = 2'd3;

  typedef enum logic {
    MAS_IDLE   = 1'b0,
    MAS_ACCESS = 1'b1
  } maState_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane placement, alignment check and load extension
// Purpose: combinational helper for the memory-access stage.
// Ports:   reqAddrLo/reqSize/reqData  - request side (execute inputs)
//          storeLanes/byteEn          - store data spread over the active lanes, lane enables
//          badAccess                  - reserved size or misaligned address
//          rspAddrLo/rspSize/rspSignExt/rspData - response side (latched access + bus data)
//          loadVal                    - extracted and extended load result
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  reqAddrLo,
  input  logic [1:0]  reqSize,
  input  logic [31:0] reqData,
  output logic [31:0] storeLanes,
  output logic [3:0]  byteEn,
  output logic        badAccess,
  input  logic [1:0]  rspAddrLo,
  input  logic [1:0]  rspSize,
  input  logic        rspSignExt,
  input  logic [31:0] rspData,
  output logic [31:0] loadVal
);

  logic [7:0]  rspByte;
  logic [15:0] rspWord;

  // Store data is replicated across all lanes, so whichever lanes are
  // enabled already carry the right bytes without a shifter.
  always_comb begin
    storeLanes = reqData;
    byteEn     = 4'b0000;
    badAccess  = 1'b0;
    case (reqSize)
      MSZ_B: begin
        storeLanes = {4{reqData[7:0]}};
        byteEn     = 4'b0001 << reqAddrLo;
      end
      MSZ_W: begin
        storeLanes = {2{reqData[15:0]}};
        byteEn     = reqAddrLo[1] ? 4'b1100 : 4'b0011;
        badAccess  = reqAddrLo[0];
      end
      MSZ_L: begin
        byteEn    = 4'b1111;
        badAccess = (reqAddrLo != 2'b00);
      end
      default: badAccess = 1'b1;
    endcase
  end

  always_comb begin
    rspByte = 8'(rspData >> {rspAddrLo, 3'b000});
    rspWord = rspAddrLo[1] ? rspData[31:16] : rspData[15:0];
    case (rspSize)
      MSZ_B:   loadVal = {{24{rspSignExt & rspByte[7]}}, rspByte};
      MSZ_W:   loadVal = {{16{rspSignExt & rspWord[15]}}, rspWord};
      default: loadVal = rspData;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with single-outstanding bus access
// Purpose: accepts execute results, forwards the register writeback on port A,
//          runs at most one load/store on the req/ack data bus and returns load
//          data on port B; reports misalignment, bus error and timeout faults.
// Ports:   clock, reset (async, active-high)
//          ex*            - execute stage outputs
//          maStall        - stage busy, upstream holds
//          bus*           - data bus (busOE read strobe, busWR write strobe, busOK/busErr ack)
//          wbIdA/wbValA   - execute writeback; wbIdB/wbValB - load writeback
//          maFault/maFaultCode/maFaultAddr - one-cycle fault report
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exValid,
  input  logic [31:0] exMemAddr,
  input  logic [31:0] exMemData,
  input  logic        exMemLoad,
  input  logic        exMemStore,
  input  logic [1:0]  exMemSize,
  input  logic        exMemSignExt,
  input  logic [6:0]  exLoadId,
  input  logic [6:0]  exRegOutId,
  input  logic [31:0] exRegOutVal,
  output logic        maStall,
  output logic [31:0] busAddr,
  output logic [31:0] busDataOut,
  output logic [3:0]  busByteEn,
  output logic        busOE,
  output logic        busWR,
  input  logic [31:0] busDataIn,
  input  logic        busOK,
  input  logic        busErr,
  output logic [6:0]  wbIdA,
  output logic [31:0] wbValA,
  output logic [6:0]  wbIdB,
  output logic [31:0] wbValB,
  output logic        maFault,
  output logic [1:0]  maFaultCode,
  output logic [31:0] maFaultAddr
);

  localparam int CNT_W = (TIMEOUT_MAX < 2) ? 1 : $clog2(TIMEOUT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_MAX);

  maState_t         state, stateNext;
  logic [CNT_W-1:0] accessCnt;
  logic [1:0]       sizeQ;
  logic             signExtQ;
  logic [6:0]       loadIdQ;

  logic        accept, memReq, illegalReq;
  logic        startAccess, loadDone, endAccess, cntInc;
  logic        faultNext;
  logic [1:0]  faultCodeNext;
  logic [31:0] storeLanes, loadVal;
  logic [3:0]  byteEn;
  logic        badAccess;

  mem_lane_align uLaneAlign (
    .reqAddrLo  (exMemAddr[1:0]),
    .reqSize    (exMemSize),
    .reqData    (exMemData),
    .storeLanes (storeLanes),
    .byteEn     (byteEn),
    .badAccess  (badAccess),
    .rspAddrLo  (busAddr[1:0]),
    .rspSize    (sizeQ),
    .rspSignExt (signExtQ),
    .rspData    (busDataIn),
    .loadVal    (loadVal)
  );

  assign accept     = exValid && !maStall;
  assign memReq     = exMemLoad || exMemStore;
  assign illegalReq = (exMemLoad && exMemStore) || badAccess;
  assign endAccess  = (state == MAS_ACCESS) && (stateNext == MAS_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MAS_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    startAccess   = 1'b0;
    loadDone      = 1'b0;
    cntInc        = 1'b0;
    faultNext     = 1'b0;
    faultCodeNext = MAF_NONE;
    case (state)
      MAS_IDLE: begin
        if (accept && memReq) begin
          if (illegalReq) begin
            faultNext     = 1'b1;
            faultCodeNext = MAF_ALIGN;
          end else begin
            startAccess = 1'b1;
            stateNext   = MAS_ACCESS;
          end
        end
      end
      MAS_ACCESS: begin
        if (busErr) begin
          faultNext     = 1'b1;
          faultCodeNext = MAF_BUS;
          stateNext     = MAS_IDLE;
        end else if (busOK) begin
          // busOE is only high for loads, so it doubles as the "load pending" flag.
          loadDone  = busOE;
          stateNext = MAS_IDLE;
        end else if (accessCnt == CNT_MAX) begin
          faultNext     = 1'b1;
          faultCodeNext = MAF_TMO;
          stateNext     = MAS_IDLE;
        end else begin
          cntInc = 1'b1;
        end
      end
      default: stateNext = MAS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      maStall     <= 1'b0;
      busAddr     <= '0;
      busDataOut  <= '0;
      busByteEn   <= '0;
      busOE       <= 1'b0;
      busWR       <= 1'b0;
      wbIdA       <= UREG_ZZR;
      wbValA      <= '0;
      wbIdB       <= UREG_ZZR;
      wbValB      <= '0;
      maFault     <= 1'b0;
      maFaultCode <= MAF_NONE;
      maFaultAddr <= '0;
      accessCnt   <= '0;
      sizeQ       <= MSZ_B;
      signExtQ    <= 1'b0;
      loadIdQ     <= UREG_ZZR;
    end else begin
      wbIdA   <= UREG_ZZR;
      wbIdB   <= UREG_ZZR;
      maFault <= faultNext;

      if (accept) begin
        wbIdA     <= exRegOutId;
        wbValA    <= exRegOutVal;
        accessCnt <= '0;
      end else if (cntInc) begin
        accessCnt <= accessCnt + CNT_W'(1);
      end

      if (faultNext) begin
        maFaultCode <= faultCodeNext;
        maFaultAddr <= (state == MAS_IDLE) ? exMemAddr : busAddr;
      end

      if (startAccess) begin
        busAddr    <= exMemAddr;
        busDataOut <= storeLanes;
        busByteEn  <= byteEn;
        busOE      <= exMemLoad;
        busWR      <= exMemStore;
        sizeQ      <= exMemSize;
        signExtQ   <= exMemSignExt;
        loadIdQ    <= exLoadId;
        maStall    <= 1'b1;
      end

      if (endAccess) begin
        busOE   <= 1'b0;
        busWR   <= 1'b0;
        maStall <= 1'b0;
      end

      if (loadDone) begin
        wbIdB  <= loadIdQ;
        wbValB <= loadVal;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exValid = 1'b0;
  logic [31:0] exMemAddr = '0;
  logic [31:0] exMemData = '0;
  logic        exMemLoad = 1'b0;
  logic        exMemStore = 1'b0;
  logic [1:0]  exMemSize = '0;
  logic        exMemSignExt = 1'b0;
  logic [6:0]  exLoadId = '0;
  logic [6:0]  exRegOutId = '0;
  logic [31:0] exRegOutVal = '0;
  logic        maStall;
  logic [31:0] busAddr, busDataOut;
  logic [3:0]  busByteEn;
  logic        busOE, busWR;
  logic [31:0] busDataIn = '0;
  logic        busOK = 1'b0;
  logic        busErr = 1'b0;
  logic [6:0]  wbIdA, wbIdB;
  logic [31:0] wbValA, wbValB;
  logic        maFault;
  logic [1:0]  maFaultCode;
  logic [31:0] maFaultAddr;

  mem_access_stage #(.TIMEOUT_MAX(TMO)) dut (
    .clock(clock), .reset(reset),
    .exValid(exValid), .exMemAddr(exMemAddr), .exMemData(exMemData),
    .exMemLoad(exMemLoad), .exMemStore(exMemStore), .exMemSize(exMemSize),
    .exMemSignExt(exMemSignExt), .exLoadId(exLoadId),
    .exRegOutId(exRegOutId), .exRegOutVal(exRegOutVal),
    .maStall(maStall),
    .busAddr(busAddr), .busDataOut(busDataOut), .busByteEn(busByteEn),
    .busOE(busOE), .busWR(busWR), .busDataIn(busDataIn),
    .busOK(busOK), .busErr(busErr),
    .wbIdA(wbIdA), .wbValA(wbValA), .wbIdB(wbIdB), .wbValB(wbValB),
    .maFault(maFault), .maFaultCode(maFaultCode), .maFaultAddr(maFaultAddr)
  );

  always #5 clock = ~clock;

  typedef struct { logic [6:0] id; logic [31:0] val; } wb_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; logic ld; } busExp_t;
  typedef struct { logic [1:0] code; logic [31:0] addr; } flt_t;

  wb_t     qA[$];
  wb_t     qB[$];
  busExp_t qBus[$];
  flt_t    qF[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on the little-endian rules.
  function automatic int nBytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit legal(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] addr);
    if (ld && st) return 1'b0;
    if (sz == 2'd3) return 1'b0;
    return (addr % nBytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] expBe(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be = '0;
    int off = int'(addr % 4);
    for (int i = 0; i < nBytes(sz); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] data, input logic [1:0] sz,
                                          input logic [31:0] addr, input logic sx);
    int n = nBytes(sz);
    int off = int'(addr % 4);
    logic [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v = (data >> (8 * off)) & mask;
    if (sx && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  logic    prevStrobe = 1'b0;
  busExp_t mBus;
  wb_t     mWb;
  flt_t    mF;

  always @(negedge clock) begin
    if (reset) begin
      prevStrobe = 1'b0;
    end else begin
      if ((busOE || busWR) && !prevStrobe) begin
        if (qBus.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected addr=0x%08h expected=none", busAddr);
        end else begin
          mBus = qBus.pop_front();
          chk("bus_addr", busAddr, mBus.addr);
          chk("bus_be", 32'(busByteEn), 32'(mBus.be));
          chk("bus_oe", 32'(busOE), 32'(mBus.ld));
          chk("bus_wr", 32'(busWR), 32'(!mBus.ld));
          if (!mBus.ld)
            for (int i = 0; i < 4; i++)
              if (mBus.be[i])
                chk("store_lane", 32'(busDataOut[8*i +: 8]),
                    32'(mBus.data[8*(i - int'(mBus.addr % 4)) +: 8]));
        end
      end
      prevStrobe = busOE || busWR;

      if (wbIdA != UREG_ZZR) begin
        if (qA.size() == 0) begin
          checks++; failures++;
          $display("FAIL wbA_unexpected id=%0d expected=none", wbIdA);
        end else begin
          mWb = qA.pop_front();
          chk("wbA_id", 32'(wbIdA), 32'(mWb.id));
          chk("wbA_val", wbValA, mWb.val);
        end
      end

      if (wbIdB != UREG_ZZR) begin
        if (qB.size() == 0) begin
          checks++; failures++;
          $display("FAIL wbB_unexpected id=%0d expected=none", wbIdB);
        end else begin
          mWb = qB.pop_front();
          chk("wbB_id", 32'(wbIdB), 32'(mWb.id));
          chk("wbB_val", wbValB, mWb.val);
        end
      end

      if (maFault) begin
        if (qF.size() == 0) begin
          checks++; failures++;
          $display("FAIL fault_unexpected code=%0d expected=none", maFaultCode);
        end else begin
          mF = qF.pop_front();
          chk("fault_code", 32'(maFaultCode), 32'(mF.code));
          chk("fault_addr", maFaultAddr, mF.addr);
        end
      end
    end
  end

  // mode: 0 = busOK, 1 = busErr (busOK random alongside), 2 = no response
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic sx,
                       input logic [6:0] lid, input logic [6:0] rid, input logic [31:0] rval,
                       input logic [31:0] ldata, input int waitCyc, input int mode);
    bit mem, ok;
    int stallCnt;
    mem = ld || st;
    ok  = legal(ld, st, sz, addr);
    @(negedge clock);
    exValid = 1'b1; exMemLoad = ld; exMemStore = st; exMemSize = sz;
    exMemAddr = addr; exMemData = sdata; exMemSignExt = sx;
    exLoadId = lid; exRegOutId = rid; exRegOutVal = rval;
    qA.push_back('{rid, rval});
    if (mem && !ok) qF.push_back('{MAF_ALIGN, addr});
    if (mem && ok)  qBus.push_back('{addr, expBe(sz, addr), sdata, ld});
    @(posedge clock); #1;
    exValid = 1'b0; exMemLoad = 1'b0; exMemStore = 1'b0;
    if (!mem) return;
    if (!ok) begin
      chk("illegal_no_strobe", 32'({busOE, busWR}), 32'd0);
      chk("illegal_no_stall", 32'(maStall), 32'd0);
      return;
    end
    stallCnt = 0;
    if (mode == 2) begin
      qF.push_back('{MAF_TMO, addr});
      for (int k = 0; k < TMO + 50; k++) begin
        @(negedge clock);
        if (!maStall) break;
        stallCnt++;
      end
      chk("tmo_stall_cycles", 32'(stallCnt), 32'(TMO + 1));
      chk("tmo_strobes", 32'({busOE, busWR}), 32'd0);
      return;
    end
    for (int k = 0; k < waitCyc; k++) begin
      @(negedge clock);
      stallCnt += int'(maStall);
    end
    @(negedge clock);
    stallCnt += int'(maStall);
    busDataIn = ldata;
    if (mode == 1) begin
      busErr = 1'b1;
      busOK  = 1'($urandom_range(0, 1));
      qF.push_back('{MAF_BUS, addr});
    end else begin
      busOK = 1'b1;
      if (ld) qB.push_back('{lid, expLoad(ldata, sz, addr, sx)});
    end
    @(posedge clock); #1;
    busOK = 1'b0; busErr = 1'b0;
    chk("stall_cycles", 32'(stallCnt), 32'(waitCyc + 1));
    chk("stall_released", 32'(maStall), 32'd0);
  endtask

  int          kind, r, waitCyc, mode;
  logic [1:0]  sz;
  logic [31:0] addr;

  initial begin
    #12;
    chk("rst_oe", 32'(busOE), 32'd0);
    chk("rst_wr", 32'(busWR), 32'd0);
    chk("rst_stall", 32'(maStall), 32'd0);
    chk("rst_fault", 32'(maFault), 32'd0);
    chk("rst_wbIdA", 32'(wbIdA), 32'(UREG_ZZR));
    chk("rst_wbIdB", 32'(wbIdB), 32'(UREG_ZZR));
    chk("rst_busAddr", busAddr, 32'd0);
    chk("rst_be", 32'(busByteEn), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // store byte at lane 3, two wait cycles
    issue(0, 1, MSZ_B, 32'h1003, 32'h0000_00A5, 0, 7'd1, 7'd2, 32'h11, 32'h0, 2, 0);
    // word load lane 1, zero- then sign-extended
    issue(1, 0, MSZ_W, 32'h2002, 32'h0, 0, 7'd9, 7'd3, 32'h22, 32'h8001_0000, 0, 0);
    issue(1, 0, MSZ_W, 32'h2002, 32'h0, 1, 7'd9, 7'd3, 32'h22, 32'h8001_1234, 0, 0);
    // post-increment long load
    issue(1, 0, MSZ_L, 32'h100, 32'h0, 0, 7'd5, 7'd4, 32'h104, 32'hCAFE_F00D, 1, 0);
    // misaligned long
    issue(1, 0, MSZ_L, 32'h3002, 32'h0, 0, 7'd5, 7'd6, 32'h33, 32'h0, 0, 0);
    // bus error together with busOK
    issue(1, 0, MSZ_L, 32'h4000, 32'h0, 0, 7'd7, 7'd8, 32'h44, 32'h1234_5678, 1, 1);
    // no response -> timeout
    issue(1, 0, MSZ_B, 32'h5001, 32'h0, 0, 7'd7, 7'd8, 32'h55, 32'h0, 0, 2);

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      r    = $urandom_range(0, 15);
      sz   = (r == 15) ? 2'd3 : 2'(r % 3);
      addr = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(nBytes(sz)) - 32'd1);
      waitCyc = $urandom_range(0, 3);
      mode    = ($urandom_range(0, 7) == 0) ? 1 : 0;
      issue(kind inside {[3:5], 9}, kind inside {[6:9]}, sz, addr, $urandom, 1'($urandom_range(0, 1)),
            7'($urandom_range(0, 126)), 7'($urandom_range(0, 126)), $urandom, $urandom, waitCyc, mode);
    end

    // reset while a load is outstanding
    @(negedge clock);
    exValid = 1'b1; exMemLoad = 1'b1; exMemSize = MSZ_L; exMemAddr = 32'h6000;
    exRegOutId = 7'd10; exRegOutVal = 32'h66; exLoadId = 7'd11;
    qA.push_back('{7'd10, 32'h66});
    qBus.push_back('{32'h6000, 4'b1111, 32'h0, 1'b1});
    @(posedge clock); #1;
    exValid = 1'b0; exMemLoad = 1'b0;
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("midrst_oe", 32'(busOE), 32'd0);
    chk("midrst_stall", 32'(maStall), 32'd0);
    chk("midrst_wbIdA", 32'(wbIdA), 32'(UREG_ZZR));
    chk("midrst_wbIdB", 32'(wbIdB), 32'(UREG_ZZR));
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1, 0, MSZ_B, 32'h7002, 32'h0, 1, 7'd12, 7'd13, 32'h77, 32'h0080_0000, 1, 0);

    repeat (3) @(negedge clock);
    chk("qA_drained", 32'(qA.size()), 32'd0);
    chk("qB_drained", 32'(qB.size()), 32'd0);
    chk("qBus_drained", 32'(qBus.size()), 32'd0);
    chk("qF_drained", 32'(qF.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
